fifo_core: RTL and testbench

//   Single-clock synchronous FIFO buffering DWIDTH-bit words between a producer
//   and a consumer in the same wclk domain. wptr/rptr are per-cycle write/read

---
 rtl/fifo_core_if.sv | 22 ++
 rtl/fifo_core.sv | 80 ++++++++
 tb/tb_fifo_core.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_core_if.sv
// Producer/consumer bundle for fifo_core: write data and strobes in,
// registered read data, read-valid pulse and error flags out.
interface fifo_core_if #(
    parameter int DWIDTH = 4
);
    logic [DWIDTH-1:0] din;
    logic              wptr;
    logic              rptr;
    logic [DWIDTH-1:0] dout;
    logic [1:0]        error;
    logic              rclk;

    modport master (
        output din, wptr, rptr,
        input  dout, error, rclk
    );

    modport slave (
        input  din, wptr, rptr,
        output dout, error, rclk
    );
endinterface

// File: rtl/fifo_core.sv
// Single-clock synchronous FIFO with registered read data.
// Ports: wclk (clock), reset (sync, active-low), bus (fifo_core_if.slave:
//   din/wptr/rptr in; dout/rclk/error out, error[0]=overflow, error[1]=underflow).
// Macro FIFO_STICKY_ERR_EN: error bits latch until reset instead of pulsing.
module fifo_core #(
    parameter int DWIDTH = 4,
    parameter int DEPTH  = 8,
    parameter int AWIDTH = 3
) (
    input logic        wclk,
    input logic        reset,
    fifo_core_if.slave bus
);
    localparam logic [AWIDTH:0] LP_FULL = (AWIDTH + 1)'(DEPTH);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_count;
    logic [DWIDTH-1:0] r_dout;
    logic              r_rclk;
    logic [1:0]        r_error;

    logic w_full;
    logic w_empty;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_ovf;
    logic w_udf;

    assign w_full   = (r_count == LP_FULL);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = bus.rptr && !w_empty;
    // A full FIFO still takes a write when a read frees a slot this cycle.
    assign w_wr_acc = bus.wptr && (!w_full || w_rd_acc);
    assign w_ovf    = bus.wptr && !w_wr_acc;
    assign w_udf    = bus.rptr && w_empty;

    // Storage is not reset; reset only blocks the write.
    always_ff @(posedge wclk) begin
        if (reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge wclk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_rclk   <= 1'b0;
            r_error  <= 2'b00;
        end else begin
            // DEPTH is a power of 2, so pointers wrap naturally.
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            r_rclk <= w_rd_acc;
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
`ifdef FIFO_STICKY_ERR_EN
            r_error <= r_error | {w_udf, w_ovf};
`else
            r_error <= {w_udf, w_ovf};
`endif
        end
    end

    assign bus.dout  = r_dout;
    assign bus.rclk  = r_rclk;
    assign bus.error = r_error;
endmodule

// File: tb/tb_fifo_core.sv
// Self-checking bench for fifo_core against a queue-based reference model.
// Covers reset, ordering, overflow/underflow, full/empty simultaneous access, wrap.
module tb_fifo_core;
    logic wclk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [3:0] q[$];
    logic [3:0] m_dout;
    logic       m_rclk;
    logic [1:0] m_err;

    fifo_core_if #(.DWIDTH(4)) bus ();

    fifo_core #(
        .DWIDTH(4),
        .DEPTH (8),
        .AWIDTH(3)
    ) dut (
        .wclk (wclk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Advance one clock with the given requests and update the model.
    task automatic cycle(input logic w, input logic r, input logic [3:0] d);
        logic       racc;
        logic       wacc;
        logic [1:0] ev;
        bus.wptr = w;
        bus.rptr = r;
        bus.din  = d;
        racc = r && (q.size() != 0);
        wacc = w && ((q.size() < 8) || racc);
        ev   = {r && (q.size() == 0), w && !wacc};
        if (racc) m_dout = q.pop_front();
        if (wacc) q.push_back(d);
        m_rclk = racc;
`ifdef FIFO_STICKY_ERR_EN
        m_err = m_err | ev;
`else
        m_err = ev;
`endif
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        bus.wptr = 1'b0;
        bus.rptr = 1'b0;
        @(posedge wclk);
        @(posedge wclk);
        #1;
        q.delete();
        m_dout = '0;
        m_rclk = 1'b0;
        m_err  = 2'b00;
        reset  = 1'b1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 4'h3);
        cycle(1'b0, 1'b1, 4'h0);
        do_reset();
        n_checks++;
        if ({bus.dout, bus.rclk, bus.error} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset: got dout=%h rclk=%b err=%b, want 0/0/00",
                     bus.dout, bus.rclk, bus.error);
        end
        cycle(1'b0, 1'b0, 4'h0);
        n_checks++;
        if ({bus.dout, bus.rclk, bus.error} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_release: got dout=%h rclk=%b err=%b, want 0/0/00",
                     bus.dout, bus.rclk, bus.error);
        end
    endtask

    task automatic test_basic();
        logic [3:0] want [3];
        logic       wantv [3];
        want  = '{4'hB, 4'h7, 4'h7};
        wantv = '{1'b1, 1'b1, 1'b0};
        do_reset();
        cycle(1'b1, 1'b0, 4'hB);
        cycle(1'b1, 1'b0, 4'h7);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 4'h0);
            n_checks++;
            if (bus.dout !== want[i] || bus.rclk !== wantv[i] ||
                bus.error !== m_err) begin
                n_errors++;
                $display("FAIL basic_rd%0d: got dout=%h rclk=%b err=%b, want dout=%h rclk=%b err=%b",
                         i, bus.dout, bus.rclk, bus.error, want[i], wantv[i], m_err);
            end
        end
        n_checks++;
        if (bus.error[1] !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_underflow: got err=%b, want err[1]=1", bus.error);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'(i));
        cycle(1'b1, 1'b0, 4'hF);
        n_checks++;
        if (bus.error[0] !== 1'b1 || bus.rclk !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_flag: got err=%b rclk=%b, want err[0]=1 rclk=0",
                     bus.error, bus.rclk);
        end
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 4'h0);
            n_checks++;
            if ({bus.dout, bus.rclk, bus.error} !== {m_dout, m_rclk, m_err} ||
                (i < 8 && bus.dout !== 4'(i))) begin
                n_errors++;
                $display("FAIL overflow_drain%0d: got dout=%h rclk=%b err=%b, want dout=%h rclk=%b err=%b",
                         i, bus.dout, bus.rclk, bus.error, m_dout, m_rclk, m_err);
            end
        end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 4'($urandom));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 4'($urandom));
            n_checks++;
            if ({bus.dout, bus.rclk, bus.error} !== {m_dout, 1'b1, 2'b00}) begin
                n_errors++;
                $display("FAIL full_rw%0d: got dout=%h rclk=%b err=%b, want dout=%h rclk=1 err=00",
                         i, bus.dout, bus.rclk, bus.error, m_dout);
            end
        end
        // Exactly 8 words remain: the 9th read must underflow.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 4'h0);
            n_checks++;
            if ({bus.dout, bus.rclk, bus.error} !== {m_dout, m_rclk, m_err}) begin
                n_errors++;
                $display("FAIL full_drain%0d: got dout=%h rclk=%b err=%b, want dout=%h rclk=%b err=%b",
                         i, bus.dout, bus.rclk, bus.error, m_dout, m_rclk, m_err);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 4'($urandom));
            for (int i = 0; i < 6; i++) begin
                cycle(1'b0, 1'b1, 4'h0);
                n_checks++;
                if ({bus.dout, bus.rclk, bus.error} !== {m_dout, m_rclk, m_err}) begin
                    n_errors++;
                    $display("FAIL wrap%0d_%0d: got dout=%h rclk=%b err=%b, want dout=%h rclk=%b err=%b",
                             pass, i, bus.dout, bus.rclk, bus.error, m_dout, m_rclk, m_err);
                end
            end
        end
    endtask

    task automatic test_empty_rw();
        do_reset();
        cycle(1'b1, 1'b1, 4'hA);
        n_checks++;
        if (bus.rclk !== 1'b0 || bus.error !== 2'b10 || bus.dout !== 4'h0) begin
            n_errors++;
            $display("FAIL empty_rw: got dout=%h rclk=%b err=%b, want dout=0 rclk=0 err=10",
                     bus.dout, bus.rclk, bus.error);
        end
        cycle(1'b0, 1'b1, 4'h0);
        n_checks++;
        if ({bus.dout, bus.rclk, bus.error} !== {4'hA, 1'b1, m_err}) begin
            n_errors++;
            $display("FAIL empty_rw_read: got dout=%h rclk=%b err=%b, want dout=a rclk=1 err=%b",
                     bus.dout, bus.rclk, bus.error, m_err);
        end
        cycle(1'b0, 1'b0, 4'h0);
`ifdef FIFO_STICKY_ERR_EN
        n_checks++;
        if (bus.error !== 2'b10) begin
            n_errors++;
            $display("FAIL sticky_hold: got err=%b, want 10", bus.error);
        end
`else
        n_checks++;
        if (bus.error !== 2'b00) begin
            n_errors++;
            $display("FAIL pulse_clear: got err=%b, want 00", bus.error);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 1'($urandom), 4'($urandom));
            n_checks++;
            if ({bus.dout, bus.rclk, bus.error} !== {m_dout, m_rclk, m_err}) begin
                n_errors++;
                $display("FAIL random%0d: got dout=%h rclk=%b err=%b, want dout=%h rclk=%b err=%b",
                         i, bus.dout, bus.rclk, bus.error, m_dout, m_rclk, m_err);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bus.din  = '0;
        bus.wptr = 1'b0;
        bus.rptr = 1'b0;
        q.delete();
        m_dout = '0;
        m_rclk = 1'b0;
        m_err  = 2'b00;
        @(posedge wclk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_wrap();
        test_empty_rw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
